// File: rtl/uart_byte_display_sched.sv
// Byte FIFO plus hold-time scheduler feeding a two-digit 7-segment display.
// Build option: define DISPLAY_BLANK_ON_IDLE_EN to blank the display once the queue drains.
module uart_byte_display_sched #(
    parameter int HOLD_CLKS  = 25000000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_L,
    input  logic                        i_RX_DV,
    input  logic [7:0]                  i_RX_Byte,
    input  logic                        i_Advance,
    output logic [7:0]                  o_Display_Byte,
    output logic                        o_Display_Valid,
    output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
    output logic                        o_Fifo_Full,
    output logic                        o_Overflow
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HOLD_W = $clog2(HOLD_CLKS);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(HOLD_CLKS - 1);

    typedef enum logic {S_IDLE, S_SHOW} state_e;

    state_e            state_q, state_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        disp_q, disp_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              fifo_empty, fifo_full, push, pop, hold_end;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        push       = i_RX_DV && !fifo_full;
        hold_end   = (state_q == S_SHOW) && ((hold_q == HOLD_END) || i_Advance);
        // Pop decisions use the pre-edge count, so a byte arriving on the
        // drain edge waits one clock and is picked up from S_IDLE.
        pop        = !fifo_empty && ((state_q == S_IDLE) || hold_end);

        state_d  = state_q;
        hold_d   = hold_q;
        disp_d   = disp_q;
        valid_d  = valid_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (i_RX_DV && fifo_full);
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        if (pop) begin
            disp_d  = mem_q[rd_ptr_q];
            valid_d = 1'b1;
            hold_d  = '0;
            state_d = S_SHOW;
        end else if (hold_end) begin
            state_d = S_IDLE;
`ifdef DISPLAY_BLANK_ON_IDLE_EN
            valid_d = 1'b0;
            disp_d  = 8'h00;
`endif
        end else if (state_q == S_SHOW) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    // Storage carries no reset; the pointers and count define its contents.
    always_ff @(posedge i_Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_RX_Byte;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
            disp_q   <= 8'h00;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
            disp_q   <= disp_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_Display_Byte  = disp_q;
    assign o_Display_Valid = valid_q;
    assign o_Fifo_Count    = count_q;
    assign o_Fifo_Full     = fifo_full;
    assign o_Overflow      = ovf_q;

endmodule
